// File: rtl/acc_alu_seq.sv
//------------------------------------------------------------------------------
// acc_alu_seq
//
// Registered accumulator ALU. Holds a W-bit accumulator plus carry (co),
// zero (z) and negative (neg) flags. Operands arrive on in_a together with
// an opcode when start is asserted. Most operations complete in a single
// clock. Shifts move one bit per clock. MUL is a W-step shift-add multiply
// that runs after the accept edge. A one-cycle done pulse marks every
// completion. An illegal opcode also raises a one-cycle op_err pulse.
//
// Ports:
//   clk     in   1    system clock, rising-edge active
//   rst_n   in   1    synchronous active-low reset
//   start   in   1    operation request, accepted only while busy=0
//   op      in   OPW  opcode, sampled with start
//   in_a    in   W    operand, sampled with start
//   acc     out  W    accumulator register
//   co      out  1    carry flag (for SUB: 1 = no borrow)
//   z       out  1    zero flag
//   neg     out  1    negative flag (sign bit of acc)
//   busy    out  1    multi-cycle shift/multiply in progress
//   done    out  1    one-cycle pulse, result and flags valid
//   op_err  out  1    one-cycle pulse alongside done for an illegal opcode
//
// Opcodes:
//   0 ADD  1 ADC  2 SUB  3 AND  4 OR  5 XOR  6 NOT  7 LDI
//   8 SHL  9 SHR  10 ASR  11 MUL  12 CLR  13-15 illegal
//------------------------------------------------------------------------------
module acc_alu_seq #(
   parameter int W   = 8,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [OPW-1:0] op,
   input  logic [W-1:0]   in_a,
   output logic [W-1:0]   acc,
   output logic           co,
   output logic           z,
   output logic           neg,
   output logic           busy,
   output logic           done,
   output logic           op_err
);

   // The shift/multiply counter must be able to hold the value W itself.
   localparam int CW = $clog2(W + 1);

   localparam logic [W-1:0]  W_AS_OPERAND = W'(W);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [CW-1:0] CNT_W        = CW'(W);

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_ADC = OPW'(1);
   localparam logic [OPW-1:0] OP_SUB = OPW'(2);
   localparam logic [OPW-1:0] OP_AND = OPW'(3);
   localparam logic [OPW-1:0] OP_OR  = OPW'(4);
   localparam logic [OPW-1:0] OP_XOR = OPW'(5);
   localparam logic [OPW-1:0] OP_NOT = OPW'(6);
   localparam logic [OPW-1:0] OP_LDI = OPW'(7);
   localparam logic [OPW-1:0] OP_SHL = OPW'(8);
   localparam logic [OPW-1:0] OP_SHR = OPW'(9);
   localparam logic [OPW-1:0] OP_ASR = OPW'(10);
   localparam logic [OPW-1:0] OP_MUL = OPW'(11);
   localparam logic [OPW-1:0] OP_CLR = OPW'(12);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_MUL
   } state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [OPW-1:0] sh_op;
   logic [W-1:0]   mcand;
   logic [W-1:0]   mplier;
   logic [2*W-1:0] prod;

   logic [W:0]     add_sum;
   logic [W-1:0]   alu_res;
   logic           alu_co;
   logic           alu_legal;

   logic [OPW-1:0] sh_kind;
   logic [W-1:0]   sh_res;
   logic           sh_out;
   logic [CW-1:0]  sh_n;
   logic           is_shift;

   logic [W:0]     mul_sum;
   logic [W-1:0]   mul_addend;
   logic [2*W-1:0] prod_next;

   // Single-cycle datapath. Computes the result and carry of every
   // one-clock opcode from the current accumulator and the operand. The
   // sequential block only uses it for ops 0-7; shifts, MUL and CLR are
   // listed explicitly so that only 13-15 are flagged as illegal.
   always_comb begin
      add_sum   = '0;
      alu_res   = acc;
      alu_co    = co;
      alu_legal = 1'b1;
      case (op)
         OP_ADD: begin
            add_sum = {1'b0, acc} + {1'b0, in_a};
            alu_res = add_sum[W-1:0];
            alu_co  = add_sum[W];
         end
         OP_ADC: begin
            add_sum = {1'b0, acc} + {1'b0, in_a} + {{W{1'b0}}, co};
            alu_res = add_sum[W-1:0];
            alu_co  = add_sum[W];
         end
         OP_SUB: begin
            add_sum = {1'b0, acc} + {1'b0, ~in_a} + {{W{1'b0}}, 1'b1};
            alu_res = add_sum[W-1:0];
            alu_co  = add_sum[W];
         end
         OP_AND: alu_res = acc & in_a;
         OP_OR:  alu_res = acc | in_a;
         OP_XOR: alu_res = acc ^ in_a;
         OP_NOT: alu_res = ~acc;
         OP_LDI: alu_res = in_a;
         OP_SHL, OP_SHR, OP_ASR, OP_MUL, OP_CLR: begin
         end
         default: alu_legal = 1'b0;
      endcase
   end

   // One-bit shift step. On the accept edge the shift kind comes straight
   // from op; on later edges it comes from the copy latched at accept,
   // because op is not re-sampled while busy. sh_out is the bit leaving
   // the accumulator on this step and becomes co on the final step.
   always_comb begin
      sh_kind = (state == ST_IDLE) ? op : sh_op;
      sh_res  = acc;
      sh_out  = 1'b0;
      case (sh_kind)
         OP_SHL: begin
            sh_res = {acc[W-2:0], 1'b0};
            sh_out = acc[W-1];
         end
         OP_SHR: begin
            sh_res = {1'b0, acc[W-1:1]};
            sh_out = acc[0];
         end
         OP_ASR: begin
            sh_res = {acc[W-1], acc[W-1:1]};
            sh_out = acc[0];
         end
         default: begin
         end
      endcase
   end

   // Shift count taken from the full operand width and clamped to W, so a
   // large operand such as 0x80 still clears the accumulator rather than
   // wrapping to a small count.
   always_comb begin
      is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
      if (in_a >= W_AS_OPERAND) begin
         sh_n = CNT_W;
      end else begin
         sh_n = in_a[CW-1:0];
      end
   end

   // One shift-add multiply step. The upper product half gains the
   // multiplicand when the current multiplier LSB is set, and the whole
   // product then moves right one place with the adder carry entering at
   // the top. After W steps prod holds the full 2W-bit product.
   always_comb begin
      mul_addend = mplier[0] ? mcand : '0;
      mul_sum    = {1'b0, prod[2*W-1:W]} + {1'b0, mul_addend};
      prod_next  = {mul_sum, prod[W-1:1]};
   end

   // Control FSM and all architectural registers. done and op_err default
   // low every cycle so they can only ever be single-cycle pulses. Flags
   // are written only at a completion edge, never while busy is high.
   // Reset wins over everything, including a shift or multiply in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         acc    <= '0;
         co     <= 1'b0;
         z      <= 1'b0;
         neg    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         op_err <= 1'b0;
         cnt    <= '0;
         sh_op  <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
      end else begin
         done   <= 1'b0;
         op_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (is_shift) begin
                     if (sh_n == '0) begin
                        z    <= (acc == '0);
                        neg  <= acc[W-1];
                        done <= 1'b1;
                     end else begin
                        acc   <= sh_res;
                        sh_op <= op;
                        cnt   <= sh_n - CNT_ONE;
                        if (sh_n == CNT_ONE) begin
                           co   <= sh_out;
                           z    <= (sh_res == '0);
                           neg  <= sh_res[W-1];
                           done <= 1'b1;
                        end else begin
                           state <= ST_SHIFT;
                           busy  <= 1'b1;
                        end
                     end
                  end else if (op == OP_MUL) begin
                     mcand  <= acc;
                     mplier <= in_a;
                     prod   <= '0;
                     cnt    <= CNT_W;
                     state  <= ST_MUL;
                     busy   <= 1'b1;
                  end else if (op == OP_CLR) begin
                     acc  <= '0;
                     co   <= 1'b0;
                     z    <= 1'b0;
                     neg  <= 1'b0;
                     done <= 1'b1;
                  end else if (!alu_legal) begin
                     done   <= 1'b1;
                     op_err <= 1'b1;
                  end else begin
                     acc  <= alu_res;
                     co   <= alu_co;
                     z    <= (alu_res == '0);
                     neg  <= alu_res[W-1];
                     done <= 1'b1;
                  end
               end
            end

            ST_SHIFT: begin
               acc <= sh_res;
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  co    <= sh_out;
                  z     <= (sh_res == '0);
                  neg   <= sh_res[W-1];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end

            ST_MUL: begin
               prod   <= prod_next;
               mplier <= mplier >> 1;
               cnt    <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  acc   <= prod_next[W-1:0];
                  co    <= |prod_next[2*W-1:W];
                  z     <= (prod_next[W-1:0] == '0);
                  neg   <= prod_next[W-1];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_alu_seq.sv
//------------------------------------------------------------------------------
// tb_acc_alu_seq
//
// Self-checking bench for acc_alu_seq (W=8). A behavioural model computes
// each operation's result with plain integer arithmetic and whole-word
// shifts, together with the expected number of edges from accept to done.
// Directed scenarios come first, followed by a randomized run.
//------------------------------------------------------------------------------
module tb_acc_alu_seq;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] in_a;
   logic [W-1:0] acc;
   logic         co;
   logic         z;
   logic         neg;
   logic         busy;
   logic         done;
   logic         op_err;

   int total;
   int bad;

   logic [W-1:0] m_acc;
   logic         m_co;
   logic         m_z;
   logic         m_neg;

   acc_alu_seq #(.W(W), .OPW(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .in_a   (in_a),
      .acc    (acc),
      .co     (co),
      .z      (z),
      .neg    (neg),
      .busy   (busy),
      .done   (done),
      .op_err (op_err)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
      end
   endtask

   // Reference model: applies one operation to the model state and returns
   // how many edges after acceptance done should appear, plus whether the
   // opcode is illegal.
   task automatic modelOp(input logic [3:0] o, input logic [W-1:0] a,
                          output int lat, output logic err);
      int          n;
      int          sum;
      logic [15:0] wide;
      err = 1'b0;
      lat = 1;
      n   = (int'(a) >= W) ? W : int'(a);
      case (o)
         4'd0: begin
            sum = int'(m_acc) + int'(a);
            m_acc = sum[7:0]; m_co = (sum >= 256);
         end
         4'd1: begin
            sum = int'(m_acc) + int'(a) + int'(m_co);
            m_acc = sum[7:0]; m_co = (sum >= 256);
         end
         4'd2: begin
            m_co  = (m_acc >= a);
            sum   = int'(m_acc) - int'(a);
            m_acc = sum[7:0];
         end
         4'd3: m_acc = m_acc & a;
         4'd4: m_acc = m_acc | a;
         4'd5: m_acc = m_acc ^ a;
         4'd6: m_acc = ~m_acc;
         4'd7: m_acc = a;
         4'd8: if (n > 0) begin
            wide  = {8'h00, m_acc} << n;
            m_acc = wide[7:0]; m_co = wide[8]; lat = n;
         end
         4'd9: if (n > 0) begin
            wide  = {m_acc, 8'h00} >> n;
            m_acc = wide[15:8]; m_co = wide[7]; lat = n;
         end
         4'd10: if (n > 0) begin
            wide  = $signed({m_acc, 8'h00}) >>> n;
            m_acc = wide[15:8]; m_co = wide[7]; lat = n;
         end
         4'd11: begin
            sum   = int'(m_acc) * int'(a);
            m_acc = sum[7:0]; m_co = (sum >= 256); lat = W + 1;
         end
         4'd12: begin
            m_acc = '0; m_co = 1'b0;
         end
         default: err = 1'b1;
      endcase
      if (o == 4'd12) begin
         m_z = 1'b0; m_neg = 1'b0;
      end else if (!err) begin
         m_z = (m_acc == '0); m_neg = m_acc[7];
      end
   endtask

   // Issues one operation, waits (bounded) for done, and checks latency,
   // busy behaviour, result, flags, op_err and the single-cycle done pulse.
   task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] a);
      int   lat_exp;
      int   lat;
      int   busy_cycles;
      logic err;
      modelOp(o, a, lat_exp, err);
      start = 1'b1; op = o; in_a = a;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      busy_cycles = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cycles++;
         @(posedge clk); #1;
         lat++;
      end
      checkOutput($sformatf("done_op%0d", o), done, 1);
      checkOutput($sformatf("latency_op%0d", o), lat, lat_exp);
      checkOutput($sformatf("busy_cycles_op%0d", o), busy_cycles, lat_exp - 1);
      checkOutput($sformatf("busy_at_done_op%0d", o), busy, 0);
      checkOutput($sformatf("acc_op%0d", o), acc, m_acc);
      checkOutput($sformatf("co_op%0d", o), co, m_co);
      checkOutput($sformatf("z_op%0d", o), z, m_z);
      checkOutput($sformatf("neg_op%0d", o), neg, m_neg);
      checkOutput($sformatf("op_err_op%0d", o), op_err, err);
      @(posedge clk); #1;
      checkOutput($sformatf("done_pulse_op%0d", o), done, 0);
   endtask

   // Main sequence: reset, directed scenarios, then randomized operations.
   initial begin
      int            done_count;
      int            lat_exp;
      logic          err;
      logic [W-1:0]  acc_at_done;
      logic          co_at_done;
      logic [3:0]    r_op;
      logic [W-1:0]  r_a;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op    = '0;
      in_a  = '0;
      m_acc = '0; m_co = 1'b0; m_z = 1'b0; m_neg = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_acc", acc, 0);
      checkOutput("rst_flags", {co, z, neg}, 0);
      checkOutput("rst_ctrl", {busy, done, op_err}, 0);
      rst_n = 1'b1;

      $display("[TB] directed: ADD with carry");
      applyStimulus(4'd7, 8'hF0);
      applyStimulus(4'd0, 8'h20);

      $display("[TB] directed: SUB then ADC");
      applyStimulus(4'd7, 8'h05);
      applyStimulus(4'd2, 8'h05);
      applyStimulus(4'd1, 8'h01);

      $display("[TB] directed: SHL 3, ASR clamped, SHR 0");
      applyStimulus(4'd7, 8'hB1);
      applyStimulus(4'd8, 8'h03);
      applyStimulus(4'd7, 8'h80);
      applyStimulus(4'd10, 8'h09);
      applyStimulus(4'd9, 8'h00);
      applyStimulus(4'd9, 8'h80);

      $display("[TB] directed: MUL with ignored start mid-operation");
      applyStimulus(4'd7, 8'h12);
      modelOp(4'd11, 8'h0F, lat_exp, err);
      start = 1'b1; op = 4'd11; in_a = 8'h0F;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("mul_busy_mid", busy, 1);
      checkOutput("mul_acc_held", acc, 8'h12);
      start = 1'b1; op = 4'd7; in_a = 8'h55;
      @(posedge clk); #1;
      start = 1'b0;
      done_count  = 0;
      acc_at_done = '0;
      co_at_done  = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (done) begin
            done_count++;
            acc_at_done = acc;
            co_at_done  = co;
         end
         @(posedge clk); #1;
      end
      checkOutput("mul_done_count", done_count, 1);
      checkOutput("mul_acc", acc_at_done, m_acc);
      checkOutput("mul_co", co_at_done, m_co);
      checkOutput("mul_acc_final", acc, m_acc);

      $display("[TB] directed: reset during MUL, then illegal opcode");
      start = 1'b1; op = 4'd11; in_a = 8'h37;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_acc = '0; m_co = 1'b0; m_z = 1'b0; m_neg = 1'b0;
      checkOutput("midrst_acc", acc, 0);
      checkOutput("midrst_flags", {co, z, neg}, 0);
      checkOutput("midrst_ctrl", {busy, done, op_err}, 0);
      @(posedge clk); #1;
      checkOutput("midrst_no_done", done, 0);
      applyStimulus(4'd14, 8'hAA);

      $display("[TB] directed: back-to-back LDI then NOT");
      modelOp(4'd7, 8'h7F, lat_exp, err);
      start = 1'b1; op = 4'd7; in_a = 8'h7F;
      @(posedge clk); #1;
      checkOutput("b2b_done1", done, 1);
      checkOutput("b2b_acc1", acc, m_acc);
      modelOp(4'd6, 8'h00, lat_exp, err);
      op = 4'd6; in_a = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("b2b_done2", done, 1);
      checkOutput("b2b_acc2", acc, m_acc);
      checkOutput("b2b_neg2", neg, m_neg);
      @(posedge clk); #1;
      checkOutput("b2b_done_end", done, 0);

      $display("[TB] randomized operations");
      for (int i = 0; i < 80; i++) begin
         r_op = 4'($urandom_range(0, 15));
         if (r_op >= 4'd8 && r_op <= 4'd10 && $urandom_range(0, 3) != 0) begin
            r_a = 8'($urandom_range(0, 10));
         end else begin
            r_a = 8'($urandom);
         end
         applyStimulus(r_op, r_a);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acc_alu_seq.md
Name: acc_alu_seq

Overview:
- Parametrised, registered successor to the combinational accumulator ALU: W-bit accumulator plus carry, zero and negative flags held in the block.
- Single-cycle ops complete in one clock. Shifts run one bit per clock; MUL runs as a W-cycle shift-add.
- start/busy/done handshake to the control FSM; operand comes from the reg_file/immediate path, result feeds the reg_file/data_mem write path.

Parameters:
W, 8, datapath/accumulator width (>=4)
OPW, 4, opcode width

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  request; accepted only when busy=0
op  in  OPW  opcode, sampled with start
in_a  in  W  operand, sampled with start
acc  out  W  accumulator register
co  out  1  carry flag register
z  out  1  zero flag register
neg  out  1  negative flag register (acc[W-1])
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse: result and flags valid
op_err  out  1  one-cycle pulse with done on an illegal opcode

Behaviour:
- Reset (rst_n=0 at edge): acc=0, co=0, z=0, neg=0, busy=0, done=0, op_err=0, FSM=IDLE. Reset has priority over everything, including mid-SHIFT/MUL; the partial result is discarded.
- Opcodes:
  - 0 ADD: {co,acc}=acc+in_a.
  - 1 ADC: {co,acc}=acc+in_a+co.
  - 2 SUB: {co,acc}=acc+~in_a+1. co=1 means no borrow.
  - 3 AND, 4 OR, 5 XOR: acc=acc op in_a; co unchanged.
  - 6 NOT: acc=~acc; co unchanged.
  - 7 LDI: acc=in_a; co unchanged.
  - 8 SHL, 9 SHR (logical), 10 ASR (sign-fill): shift count n=min(in_a,W).
  - 11 MUL: acc=low W bits of acc*in_a (unsigned); co=1 iff the high W bits are nonzero.
  - 12 CLR: acc=0, co=0, z=0, neg=0.
  - 13-15 illegal: acc and flags unchanged, op_err=1 with done.
- FSM states: IDLE, SHIFT, MUL.
- IDLE with start=1:
  - Single-cycle ops (0-7, 12-15), and shifts with n=0: result written at the same edge; done=1 for the following cycle; FSM stays IDLE; busy stays 0. For n=0, acc and co are unchanged.
  - Shifts with n>=1: first bit shifted at the accept edge; cnt=n-1.
    - If cnt=0: done next cycle, stay IDLE.
    - Otherwise go to SHIFT, busy=1.
  - MUL: latch multiplicand=acc and multiplier=in_a, clear the 2W-bit product; go to MUL with cnt=W; busy=1.
- SHIFT:
  - One bit per edge. co = last bit shifted out; SHL shifts in 0.
  - cnt decrements each edge. On the edge where the final bit shifts, go to IDLE, busy=0, done=1 next cycle.
  - Total: n accept-to-result edges.
- MUL:
  - Each edge: if multiplier LSB=1, add multiplicand to the upper product half; then shift the product and multiplier right.
  - After W edges, write acc and co, go to IDLE, done=1.
  - acc holds the original value until the final edge.
- Flags:
  - z and neg are recomputed from the new acc at every completion, except op_err and CLR.
  - Flags never change while busy=1.
- Handshake:
  - start while busy=1 is ignored; no queuing; op/in_a are not re-sampled.
  - done and op_err are single-cycle registered pulses.
  - start may be asserted in the same cycle done=1; it is accepted (back-to-back ops allowed).
- Width rules:
  - All arithmetic is modulo 2^W; carry is bit W of the (W+1)-bit sum.
  - n is compared on the full in_a width: in_a>=W clamps to W, so a shift by W leaves acc=0 (ASR: all sign bits).

Test Plan:
- ADD: acc=0xF0, ADD in_a=0x20 -> acc=0x10, co=1, z=0, neg=0; done 1 cycle after accept, busy never high.
- SUB then ADC: acc=0x05, SUB 0x05 -> acc=0x00, co=1, z=1. Next ADC 0x01 -> acc=0x02, co=0.
- SHL: acc=0xB1, SHL 3 -> busy high 2 cycles; after 3rd edge acc=0x88, co=1, neg=1, done pulse. ASR: acc=0x80, ASR 9 -> clamps to 8; acc=0xFF, co=1 after 8 edges.
- MUL: acc=0x12, MUL 0x0F -> after 8 edges acc=0x0E, co=1. A start issued mid-MUL is ignored: acc/flags are unaffected, and only one done occurs.
- Reset: rst_n=0 at MUL cycle 4 -> next cycle acc=0, all flags 0, busy=0, no done. Then op=14 -> done=1, op_err=1, acc unchanged.
- Back-to-back: start held high with LDI 0x7F then NOT on consecutive accepted cycles -> acc=0x7F then 0x80, neg=1, two done pulses.
